// File: rtl/apb_master_fsm_pkg.sv
// Shared types, widths and the slave address decode for the APB initiator.
package apb_master_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned NSLV      = 4;
    localparam int unsigned REGION_W  = 6;
    localparam int unsigned SEL_IDX_W = $clog2(NSLV);

    // Slave n occupies region SLV_BASE_REGION + n, each SLV_SPAN bytes wide.
    localparam logic [REGION_W-1:0] SLV_BASE_REGION = 6'h20;
    localparam logic [ADDR_W-1:0]   SLV_BASE_ADDR   = 32'h8000_0000;
    localparam logic [ADDR_W-1:0]   SLV_SPAN        = 32'h0400_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_t;

    typedef struct packed {
        logic            hit;
        logic [NSLV-1:0] sel;
    } dec_t;

    function automatic dec_t apb_decode(input logic [REGION_W-1:0] region);
        logic [REGION_W-1:0] off;
        dec_t                d;
        off   = region - SLV_BASE_REGION;
        d.hit = (32'(off) < NSLV);
        d.sel = d.hit ? (NSLV'(1) << off[SEL_IDX_W-1:0]) : '0;
        return d;
    endfunction

endpackage

// File: rtl/apb_master_fsm_if.sv
// Request/response handshake and APB bus signals of the bridge's APB initiator.
interface apb_master_fsm_if;
    import apb_master_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [NSLV-1:0]   PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_fsm.sv
// APB initiator: accepts one request per handshake, runs SETUP/ACCESS on the
// decoded slave (or a one-cycle ERR for unmapped addresses), returns one response.
module apb_master_fsm
    import apb_master_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    apb_master_fsm_if.master bus
);

    state_t            r_state;
    logic [NSLV-1:0]   r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    dec_t w_dec;
    logic w_ready;
    logic w_accept;

    assign w_dec    = apb_decode(bus.req_addr[ADDR_W-1 -: REGION_W]);
    assign w_ready  = HRESETn && (r_state != SETUP);
    assign w_accept = bus.req_valid && w_ready;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= IDLE;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                default: begin
                    // IDLE, ACCESS and ERR all retire the previous transfer and may accept the next.
                    if (r_state == ACCESS) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.PRDATA;
                    end
                    if (r_state == ERR) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end
                    r_state   <= IDLE;
                    r_psel    <= '0;
                    r_penable <= 1'b0;
                    if (w_accept) begin
                        if (w_dec.hit) begin
                            r_state  <= SETUP;
                            r_psel   <= w_dec.sel;
                            r_paddr  <= bus.req_addr;
                            r_pwrite <= bus.req_write;
                            if (bus.req_write) begin
                                r_pwdata <= bus.req_wdata;
                            end
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.PSELx     = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: per-cycle timeline model plus literal response checks.
module tb_apb_master_fsm;
    import apb_master_pkg::*;

    localparam int MAXC = 400;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    apb_master_fsm_if bus ();

    apb_master_fsm dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    // PRDATA source: fixed value or a fresh random word every cycle.
    bit          prd_rand  = 1'b0;
    logic [31:0] prd_fixed = 32'h0;
    always @(posedge HCLK) begin
        #2;
        bus.PRDATA = prd_rand ? $urandom : prd_fixed;
    end

    // Expected timeline, indexed by cycle number (cycle k follows clock edge k).
    logic [NSLV-1:0] e_psel   [MAXC];
    logic            e_pen    [MAXC];
    logic            e_setup  [MAXC];
    logic            e_rsp    [MAXC];
    logic            e_err    [MAXC];
    int              e_rdsrc  [MAXC];
    logic [31:0]     e_paddr  [MAXC];
    logic            e_pwrite [MAXC];
    logic [31:0]     e_pwdata [MAXC];
    logic [31:0]     prd_hist [MAXC];

    typedef struct {
        int          c;
        logic        err;
        logic [31:0] rd;
    } rsp_t;
    rsp_t rsp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NSLV-1:0] exp_sel(input logic [31:0] a);
        logic [3:0] one;
        int         idx;
        one = 4'b0001;
        if (a >= 32'h8000_0000 && a < 32'h9000_0000) begin
            idx = int'((a - 32'h8000_0000) / 32'h0400_0000);
            return one << idx;
        end
        return '0;
    endfunction

    task automatic model_reset(input int s);
        for (int j = s; j < MAXC; j++) begin
            e_psel[j] = '0;  e_pen[j] = 1'b0; e_setup[j] = 1'b0;
            e_rsp[j] = 1'b0; e_err[j] = 1'b0; e_rdsrc[j] = -1;
            e_paddr[j] = '0; e_pwrite[j] = 1'b0; e_pwdata[j] = '0;
        end
    endtask

    task automatic model_accept(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [NSLV-1:0] s;
        s = exp_sel(a);
        if (s != '0) begin
            e_psel[k+1] = s; e_psel[k+2] = s; e_pen[k+2] = 1'b1; e_setup[k+1] = 1'b1;
            e_rsp[k+3] = 1'b1; e_err[k+3] = 1'b0; e_rdsrc[k+3] = w ? -1 : k + 2;
            for (int j = k + 1; j < MAXC; j++) begin
                e_paddr[j] = a; e_pwrite[j] = w;
                if (w) e_pwdata[j] = d;
            end
        end else begin
            e_rsp[k+2] = 1'b1; e_err[k+2] = 1'b1; e_rdsrc[k+2] = -1;
        end
    endtask

    // Per-cycle compare against the timeline, then advance the model.
    initial begin
        logic        exp_ready;
        logic [31:0] exp_rd;
        int          k;
        model_reset(0);
        forever begin
            @(negedge HCLK);
            k = cyc;
            if (k + 4 < MAXC) begin
                exp_ready = HRESETn && !e_setup[k];
                if (k >= 1) begin
                    exp_rd = (e_rsp[k] && e_rdsrc[k] >= 0) ? prd_hist[e_rdsrc[k]] : 32'h0;
                    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                    chk("PSELx",     32'(bus.PSELx),     32'(e_psel[k]));
                    chk("PENABLE",   32'(bus.PENABLE),   32'(e_pen[k]));
                    chk("PWRITE",    32'(bus.PWRITE),    32'(e_pwrite[k]));
                    chk("PADDR",     bus.PADDR,          e_paddr[k]);
                    chk("PWDATA",    bus.PWDATA,         e_pwdata[k]);
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp[k]));
                    chk("rsp_err",   32'(bus.rsp_err),   32'(e_err[k]));
                    chk("rsp_rdata", bus.rsp_rdata,      exp_rd);
                    if (bus.rsp_valid === 1'b1) rsp_q.push_back('{k, bus.rsp_err, bus.rsp_rdata});
                end
                prd_hist[k] = bus.PRDATA;
                if (HRESETn !== 1'b1) model_reset(k + 1);
                else if (bus.req_valid && exp_ready) model_accept(k, bus.req_write, bus.req_addr, bus.req_wdata);
            end
        end
    end

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
        acc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            if (bus.req_ready === 1'b1) begin
                acc = cyc;
                @(posedge HCLK); #1;
                break;
            end
            @(posedge HCLK); #1;
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL issue_timeout addr %h: got no accept expected accept within 10 cycles", a);
        end
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    task automatic pop_rsp(input string nm, input int acc, input int lat, input logic e_e,
                           input bit chk_rd, input logic [31:0] e_rd);
        rsp_t r;
        if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: got no response expected one", nm);
        end else begin
            r = rsp_q.pop_front();
            chk({nm, "_lat"}, 32'(r.c - acc), 32'(lat));
            chk({nm, "_err"}, 32'(r.err), 32'(e_e));
            if (chk_rd) chk({nm, "_rdata"}, r.rd, e_rd);
        end
    endtask

    initial begin
        int a1, a2;
        HRESETn = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_PSELx", 32'(bus.PSELx), 32'h0);
        chk("rst_PENABLE", 32'(bus.PENABLE), 32'h0);
        chk("rst_PADDR", bus.PADDR, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge HCLK); #1;

        // Read from slave 2
        prd_fixed = 32'hDEAD_BEEF;
        issue(1'b0, 32'h8800_0010, 32'h0, a1);
        idle(5);
        pop_rsp("rd_s2", a1, 3, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Write to slave 0
        prd_fixed = 32'hCAFE_0001;
        issue(1'b1, 32'h8000_0004, 32'h1234_5678, a1);
        idle(5);
        pop_rsp("wr_s0", a1, 3, 1'b0, 1'b1, 32'h0);
        chk("wr_pwdata_hold", bus.PWDATA, 32'h1234_5678);
        chk("wr_pwrite_hold", 32'(bus.PWRITE), 32'h1);

        // Back-to-back write then read, random PRDATA
        prd_rand = 1'b1;
        issue(1'b1, 32'h8400_0000, 32'hA5A5_0001, a1);
        issue(1'b0, 32'h8C00_0008, 32'hFFFF_FFFF, a2);
        idle(6);
        prd_rand = 1'b0;
        chk("b2b_gap", 32'(a2 - a1), 32'd2);
        pop_rsp("b2b_wr", a1, 3, 1'b0, 1'b1, 32'h0);
        pop_rsp("b2b_rd", a1, 5, 1'b0, 1'b0, 32'h0);
        chk("b2b_pwdata_hold", bus.PWDATA, 32'hA5A5_0001);

        // Out-of-map then an immediate in-map read
        prd_fixed = 32'h1111_2222;
        issue(1'b0, 32'h9000_0000, 32'h0, a1);
        issue(1'b0, 32'h8000_0100, 32'h0, a2);
        idle(6);
        chk("oom_gap", 32'(a2 - a1), 32'd1);
        pop_rsp("oom", a1, 2, 1'b1, 1'b1, 32'h0);
        pop_rsp("oom_next_rd", a1, 4, 1'b0, 1'b1, 32'h1111_2222);

        // In-map read followed by an error accepted in ACCESS
        issue(1'b0, 32'h8000_0000, 32'h0, a1);
        issue(1'b0, 32'h0000_0000, 32'h0, a2);
        idle(6);
        pop_rsp("ok_then_err", a1, 3, 1'b0, 1'b1, 32'h1111_2222);
        pop_rsp("err_after_ok", a1, 4, 1'b1, 1'b1, 32'h0);

        // Consecutive errors at one per cycle
        issue(1'b1, 32'hF000_0000, 32'h5, a1);
        issue(1'b0, 32'h7C00_0000, 32'h0, a2);
        idle(5);
        chk("err_err_gap", 32'(a2 - a1), 32'd1);
        pop_rsp("err1", a1, 2, 1'b1, 1'b1, 32'h0);
        pop_rsp("err2", a1, 3, 1'b1, 1'b1, 32'h0);

        // Reset during ACCESS drops the transfer
        prd_fixed = 32'h5555_AAAA;
        issue(1'b0, 32'h8C00_0000, 32'h0, a1);
        idle(1);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("mid_rst_PSELx", 32'(bus.PSELx), 32'h0);
        chk("mid_rst_PENABLE", 32'(bus.PENABLE), 32'h0);
        chk("mid_rst_PADDR", bus.PADDR, 32'h0);
        chk("mid_rst_PWDATA", bus.PWDATA, 32'h0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h1);
        @(posedge HCLK); #1;
        idle(4);
        chk("mid_rst_no_rsp", 32'(rsp_q.size()), 32'h0);

        // Recovery after reset
        issue(1'b1, 32'h8400_0040, 32'h0BAD_F00D, a1);
        idle(5);
        pop_rsp("post_rst_wr", a1, 3, 1'b0, 1'b1, 32'h0);
        chk("post_rst_pwdata", bus.PWDATA, 32'h0BAD_F00D);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
